// File: rtl/store_commit_queue.sv
// In-order store queue: buffers speculative stores, marks them committed on fireStore/fireStore1 and drains committed ones to the D$.
// Outputs depend on registered state only; enqueue/commit at edge N are visible to commit/drain in cycle N+1.
module store_commit_queue #(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  input  logic [31:0]   enq_addr,
  input  logic [31:0]   enq_data,
  input  logic [3:0]    enq_be,
  output logic          enq_ready,
  input  logic          fireStore,
  input  logic          fireStore1,
  input  logic          flush,
  output logic          mem_req_valid,
  output logic [31:0]   mem_req_addr,
  output logic [31:0]   mem_req_data,
  output logic [3:0]    mem_req_be,
  input  logic          mem_req_ready,
  output logic          sq_empty,
  output logic [PW-1:0] cmt_cnt
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [29:0] ent_addr_q [DEPTH];
  logic [31:0] ent_data_q [DEPTH];
  logic [3:0]  ent_be_q   [DEPTH];

  logic [PW-1:0] cnt;
  logic [PW-1:0] uncmt;
  logic [PW-1:0] k;
  logic [PW-1:0] adv;
  logic          enq_fire;
  logic          drain_fire;
  logic [IW-1:0] head_idx;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^enq_addr[1:0];

  always_comb begin
    cnt        = tail_q - head_q;
    uncmt      = tail_q - cmt_q;
    head_idx   = head_q[IW-1:0];
    enq_fire   = enq_valid && (cnt != PW'(DEPTH)) && !flush;
    drain_fire = (head_q != cmt_q) && mem_req_ready;
  end

  // Commit saturates at tail; flush then truncates tail back to the new commit point.
  always_comb begin
    k      = PW'(fireStore) + PW'(fireStore1);
    adv    = (k > uncmt) ? uncmt : k;
    cmt_d  = cmt_q + adv;
    head_d = head_q + PW'(drain_fire);
    tail_d = tail_q + PW'(enq_fire);
    if (flush) begin
      tail_d = cmt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      ent_addr_q[tail_q[IW-1:0]] <= enq_addr[31:2];
      ent_data_q[tail_q[IW-1:0]] <= enq_data;
      ent_be_q[tail_q[IW-1:0]]   <= enq_be;
    end
  end

  // Payload is unreset, so the request bus is gated to zero whenever nothing committed is held.
  always_comb begin
    enq_ready     = (cnt != PW'(DEPTH));
    sq_empty      = (cnt == '0);
    cmt_cnt       = cmt_q - head_q;
    mem_req_valid = (head_q != cmt_q);
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_be    = '0;
    if (mem_req_valid) begin
      mem_req_addr = {ent_addr_q[head_idx], 2'b00};
      mem_req_data = ent_data_q[head_idx];
      mem_req_be   = ent_be_q[head_idx];
    end
  end

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue: commit, back-pressure, flush, full/wrap, over-commit, async reset.
module tb_store_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_be;
  logic        enq_ready;
  logic        fireStore;
  logic        fireStore1;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready;
  logic        sq_empty;
  logic [3:0]  cmt_cnt;

  int checks = 0;
  int errors = 0;
  int uncmt_model = 0;

  store_commit_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_be(enq_be),
    .enq_ready(enq_ready),
    .fireStore(fireStore), .fireStore1(fireStore1), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
    .sq_empty(sq_empty), .cmt_cnt(cmt_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_data  = d;
    enq_be    = b;
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = 0; enq_addr = 0; enq_data = 0; enq_be = 0;
    fireStore = 0; fireStore1 = 0; flush = 0; mem_req_ready = 0;
    #2;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_data", mem_req_data, 0);
    chk("rst_be", mem_req_be, 0);
    chk("rst_empty", sq_empty, 1);
    chk("rst_cmt_cnt", cmt_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // 1: single store
    enq(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("t1_uncommitted_valid", mem_req_valid, 0);
    chk("t1_not_empty", sq_empty, 0);
    fireStore = 1'b1;
    step();
    fireStore = 1'b0;
    chk("t1_valid", mem_req_valid, 1);
    chk("t1_addr", mem_req_addr, 32'h8000_0010);
    chk("t1_data", mem_req_data, 32'hDEAD_BEEF);
    chk("t1_be", mem_req_be, 4'hF);
    chk("t1_cmt_cnt", cmt_cnt, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t1_empty_after", sq_empty, 1);
    chk("t1_valid_after", mem_req_valid, 0);

    // 2: dual commit under back-pressure; store 0 has addr low bits set
    enq(32'h1000_0003, 32'h2000_0000, 4'h1);
    enq(32'h1000_0004, 32'h2000_0001, 4'h3);
    enq(32'h1000_0008, 32'h2000_0002, 4'hC);
    fireStore = 1'b1; fireStore1 = 1'b1;
    step();
    fireStore = 1'b0; fireStore1 = 1'b0;
    chk("t2_cmt_cnt", cmt_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", mem_req_valid, 1);
      chk("t2_hold_addr", mem_req_addr, 32'h1000_0000);
      chk("t2_hold_data", mem_req_data, 32'h2000_0000);
      chk("t2_hold_be", mem_req_be, 4'h1);
      step();
    end
    mem_req_ready = 1'b1;
    chk("t2_d0_data", mem_req_data, 32'h2000_0000);
    step();
    chk("t2_d1_addr", mem_req_addr, 32'h1000_0004);
    chk("t2_d1_data", mem_req_data, 32'h2000_0001);
    chk("t2_d1_be", mem_req_be, 4'h3);
    step();
    mem_req_ready = 1'b0;
    chk("t2_valid_low", mem_req_valid, 0);
    chk("t2_third_held", sq_empty, 0);
    chk("t2_cmt_cnt_0", cmt_cnt, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t2_flush_clears", sq_empty, 1);

    // 3: flush with same-cycle commit and enqueue
    for (int i = 0; i < 4; i++) enq(32'h3000_0000 + 32'(i * 4), 32'h3000_0000 + 32'(i), 4'hF);
    fireStore = 1'b1;
    step();
    fireStore = 1'b0;
    chk("t3_cmt_cnt_1", cmt_cnt, 1);
    fireStore1 = 1'b1; flush = 1'b1;
    enq_valid = 1'b1; enq_addr = 32'h3BAD_0000; enq_data = 32'h3BAD_3BAD; enq_be = 4'hF;
    step();
    fireStore1 = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    chk("t3_cmt_cnt_2", cmt_cnt, 2);
    chk("t3_enq_ready", enq_ready, 1);
    mem_req_ready = 1'b1;
    chk("t3_w0", mem_req_data, 32'h3000_0000);
    step();
    chk("t3_w1", mem_req_data, 32'h3000_0001);
    step();
    mem_req_ready = 1'b0;
    chk("t3_valid_low", mem_req_valid, 0);
    chk("t3_empty", sq_empty, 1);

    // 4: full, 9th enqueue refused, then wrap with a second batch
    for (int i = 0; i < 8; i++) enq(32'h4000_0000 + 32'(i * 4), 32'h4000_0000 + 32'(i), 4'hF);
    chk("t4_full_ready", enq_ready, 0);
    chk("t4_full_empty", sq_empty, 0);
    enq(32'h4999_0000, 32'h4999_4999, 4'hF);
    fireStore = 1'b1; fireStore1 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    fireStore = 1'b0; fireStore1 = 1'b0;
    chk("t4_cmt_cnt_8", cmt_cnt, 8);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_data", mem_req_data, 32'h4000_0000 + 32'(i));
      chk("t4_drain_addr", mem_req_addr, 32'h4000_0000 + 32'(i * 4));
      step();
    end
    mem_req_ready = 1'b0;
    chk("t4_empty", sq_empty, 1);
    for (int i = 0; i < 8; i++) enq(32'h5000_0000 + 32'(i * 4), 32'h5000_0000 + 32'(i), 4'h5);
    chk("t4b_full_ready", enq_ready, 0);
    fireStore = 1'b1;
    for (int i = 0; i < 8; i++) step();
    fireStore = 1'b0;
    chk("t4b_cmt_cnt_8", cmt_cnt, 8);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4b_drain_data", mem_req_data, 32'h5000_0000 + 32'(i));
      step();
    end
    mem_req_ready = 1'b0;
    chk("t4b_empty", sq_empty, 1);
    chk("t4b_valid_low", mem_req_valid, 0);

    // 5: fireStore1 alone, then over-commit saturation
    enq(32'h6000_0000, 32'h6000_0000, 4'hF);
    fireStore1 = 1'b1;
    step();
    fireStore1 = 1'b0;
    chk("t5_fs1_cmt_cnt", cmt_cnt, 1);
    chk("t5_fs1_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t5_drained", sq_empty, 1);
    enq(32'h6000_0004, 32'h6000_0001, 4'hF);
    uncmt_model = 1;
    fireStore = 1'b1; fireStore1 = 1'b1;
    if (2 > uncmt_model) $display("NOTE protocol violation: commit of 2 with %0d uncommitted entry", uncmt_model);
    step();
    fireStore = 1'b0; fireStore1 = 1'b0;
    chk("t5_sat_cmt_cnt", cmt_cnt, 1);
    enq(32'h6000_0008, 32'h6000_0002, 4'hF);
    chk("t5_new_uncommitted", cmt_cnt, 1);
    fireStore = 1'b1;
    step();
    fireStore = 1'b0;
    chk("t5_new_committed", cmt_cnt, 2);

    // 6: async reset between edges while a committed store is presented
    chk("t6_pre_valid", mem_req_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_valid_drop", mem_req_valid, 0);
    chk("t6_enq_ready", enq_ready, 1);
    chk("t6_empty", sq_empty, 1);
    chk("t6_cmt_cnt", cmt_cnt, 0);
    chk("t6_addr", mem_req_addr, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_valid", mem_req_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
